hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Central pipeline control: generates write-enables and bubble/flush strobes for every inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Sits directly upstream of the per-field enabled pipeline registers; its enables drive their hold/load select.
- Handles load-use hazards, taken-branch flushes, multi-cycle data-memory stalls and halt drain.

Parameters:
- ADDR_W, 4, register-specifier width.
- MEM_TIMEOUT, 255, consecutive dmem_busy cycles before mem_timeout sets.
- DRAIN_CYCLES, 3, cycles from halt in ID until halted asserts.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_rs  input  ADDR_W  ID-stage source register 1.
- id_rt  input  ADDR_W  ID-stage source register 2.
- id_rs_vld  input  1  id_rs is actually read.
- id_rt_vld  input  1  id_rt is actually read.
- id_halt  input  1  halt instruction decoded in ID.
- ex_dst  input  ADDR_W  EX-stage destination register.
- ex_mem_read  input  1  EX-stage instruction is a load.
- ex_br_taken  input  1  branch/jump resolved taken in EX.
- dmem_busy  input  1  data memory not ready this cycle.
- pc_en  output  1  PC load enable.
- if_id_en  output  1  IF/ID load enable.
- id_ex_en  output  1  ID/EX load enable.
- ex_mem_en  output  1  EX/MEM load enable.
- mem_wb_en  output  1  MEM/WB load enable.
- if_id_flush  output  1  IF/ID loads NOP.
- id_ex_flush  output  1  ID/EX loads NOP (bubble).
- halted  output  1  pipeline halted.
- mem_timeout  output  1  sticky memory-stall timeout flag.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - State RUN, counters 0, halted=0, mem_timeout=0.
  - During reset, all enables=0 and all flushes=0.
- Output timing:
  - Enables and flushes are combinational from current state and current inputs; no added latency.
  - State and counters update on rising clk.
- States: RUN, MEM_STALL, DRAIN, HALTED.
- Load-use hazard (lu) = ex_mem_read & ex_dst!=0 & ((id_rs_vld & id_rs==ex_dst) | (id_rt_vld & id_rt==ex_dst)).
- Priority within RUN and DRAIN: dmem_busy > ex_br_taken > lu > id_halt.
- dmem_busy, any state except HALTED:
  - All enables=0, flushes=0; next state MEM_STALL.
  - Stall counter increments, saturating at MEM_TIMEOUT; mem_timeout sets when the counter reaches MEM_TIMEOUT and holds until reset.
- MEM_STALL, dmem_busy=0:
  - Counter clears.
  - Return to the state held before the stall (RUN or DRAIN); that cycle is evaluated as that state.
- RUN, ex_br_taken=1:
  - All enables=1, if_id_flush=1, id_ex_flush=1.
  - lu and id_halt are ignored (the younger instructions are squashed).
- RUN, lu=1, no branch:
  - pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1.
  - Exactly one bubble per load; remains in RUN.
- RUN, id_halt=1, no higher-priority event:
  - pc_en=0, if_id_en=0, other enables=1, no flush.
  - Go to DRAIN; drain counter loads DRAIN_CYCLES-1.
- DRAIN:
  - pc_en=0, if_id_en=0, id_ex_en=1, ex_mem_en=1, mem_wb_en=1, id_ex_flush=1.
  - Counter decrements each non-stalled cycle. At 0, go to HALTED.
  - If ex_br_taken=1 in DRAIN (older branch squashes the halt): full-flush outputs, return to RUN, counter clears.
- HALTED:
  - All enables=0, flushes=0, halted=1.
  - dmem_busy is ignored.
  - Only rst_n exits.
- Reset asserted mid-stall or mid-drain: immediate return to reset values, independent of clk.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - Adds outputs lu_stall_cnt[15:0], br_flush_cnt[15:0], mem_stall_cnt[15:0].
  - Each increments once per cycle in which its condition drives the outputs, saturates at 16'hFFFF, and resets to 0.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load-use: ex_mem_read=1, ex_dst=3, id_rs=3, id_rs_vld=1 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1. The next cycle, with the load moved on (ex_mem_read=0), all enables=1.
- Register 0 / invalid operand: ex_dst=0 with id_rs=0, or id_rt matching with id_rt_vld=0 -> no stall, all enables=1.
- Branch plus load-use in the same cycle: ex_br_taken=1, lu=1 -> pc_en=1, if_id_flush=1, id_ex_flush=1, no stall.
- Memory stall: dmem_busy held 4 cycles -> all enables=0 for 4 cycles, then normal. With MEM_TIMEOUT=2 and dmem_busy held 3 cycles -> mem_timeout=1 from the 3rd cycle, sticky after dmem_busy drops.
- Halt: id_halt=1 in RUN -> halted=1 exactly DRAIN_CYCLES(3) cycles later, all enables=0 thereafter. With ex_br_taken=1 in the 2nd DRAIN cycle -> back to RUN, halted stays 0.
- Asynchronous reset: rst_n low mid-DRAIN between clock edges -> halted=0, enables=0 immediately. After release, the first cycle is RUN with all enables=1.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: PC and inter-stage register enables plus bubble/flush strobes.
// Latency: enables and flushes are combinational from state and inputs; state and counters update on rising clk.
// Backpressure: dmem_busy freezes every stage; load-use holds PC and IF/ID; halt drains and then freezes.
// Optional HAZARD_PERF_CNT_EN adds saturating lu/branch/mem-stall event counters.
module hazard_stall_ctrl #(
  parameter int ADDR_W       = 4,
  parameter int MEM_TIMEOUT  = 255,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_rs_vld,
  input  logic              id_rt_vld,
  input  logic              id_halt,
  input  logic [ADDR_W-1:0] ex_dst,
  input  logic              ex_mem_read,
  input  logic              ex_br_taken,
  input  logic              dmem_busy,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              halted,
  output logic              mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]       lu_stall_cnt,
  output logic [15:0]       br_flush_cnt,
  output logic [15:0]       mem_stall_cnt
`endif
);

  localparam int SCW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int DCW = (DRAIN_CYCLES < 3) ? 1 : $clog2(DRAIN_CYCLES);
  localparam logic [SCW-1:0] STALL_MAX  = SCW'(MEM_TIMEOUT);
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);
  localparam logic [DCW-1:0] DRAIN_ONE  = DCW'(1);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MEM_STALL = 2'd1,
    ST_DRAIN     = 2'd2,
    ST_HALTED    = 2'd3
  } state_t;

  state_t         state, state_nxt;
  state_t         ret_state, ret_nxt;
  state_t         eval_state;
  logic [SCW-1:0] stall_cnt, stall_nxt;
  logic [DCW-1:0] drain_cnt, drain_nxt;
  logic           timeout_nxt;
  logic           lu;

  // Load-use: ID reads a register that the load now in EX has not yet produced; r0 never hazards.
  assign lu = ex_mem_read && (ex_dst != '0) &&
              ((id_rs_vld && (id_rs == ex_dst)) || (id_rt_vld && (id_rt == ex_dst)));

  // The cycle a memory stall ends behaves exactly like the state that was interrupted.
  assign eval_state = (state == ST_MEM_STALL) ? ret_state : state;

  assign halted = (state == ST_HALTED);

  // State, stall/drain counters and the sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      ret_state   <= ST_RUN;
      stall_cnt   <= '0;
      drain_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      ret_state   <= ret_nxt;
      stall_cnt   <= stall_nxt;
      drain_cnt   <= drain_nxt;
      mem_timeout <= timeout_nxt;
    end
  end

  // Next-state and stage-control decode; priority is dmem_busy > branch > load-use > halt.
  always_comb begin
    state_nxt   = state;
    ret_nxt     = ret_state;
    stall_nxt   = stall_cnt;
    drain_nxt   = drain_cnt;
    timeout_nxt = mem_timeout;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;

    if ((state != ST_HALTED) && dmem_busy) begin
      // Whole pipe frozen; remember where to resume once memory answers.
      state_nxt = ST_MEM_STALL;
      ret_nxt   = eval_state;
      if (stall_cnt != STALL_MAX) begin
        stall_nxt = stall_cnt + 1'b1;
      end
      if (stall_nxt == STALL_MAX) begin
        timeout_nxt = 1'b1;
      end
    end else begin
      stall_nxt = '0;
      case (eval_state)
        ST_RUN: begin
          state_nxt = ST_RUN;
          pc_en     = 1'b1;
          if_id_en  = 1'b1;
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
          mem_wb_en = 1'b1;
          if (ex_br_taken) begin
            // Younger instructions in IF and ID are wrong-path: squash both.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (lu) begin
            // Hold the consumer in ID one cycle and insert a bubble behind the load.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end else if (id_halt) begin
            // Halt moves on to EX; stop fetching and drain what is older.
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            state_nxt = ST_DRAIN;
            drain_nxt = DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
          mem_wb_en = 1'b1;
          if (ex_br_taken) begin
            // An older branch resolved taken: the halt was on the wrong path.
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_nxt   = ST_RUN;
            drain_nxt   = '0;
          end else begin
            id_ex_flush = 1'b1;
            if (drain_cnt != '0) begin
              drain_nxt = drain_cnt - 1'b1;
            end
            if (drain_cnt <= DRAIN_ONE) begin
              state_nxt = ST_HALTED;
            end else begin
              state_nxt = ST_DRAIN;
            end
          end
        end
        ST_HALTED: begin
          state_nxt = ST_HALTED;
        end
        default: begin
          state_nxt = ST_RUN;
        end
      endcase
    end

    // Nothing may load while reset is held, regardless of the decoded state.
    if (!rst_n) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic mem_ev, br_ev, lu_ev;

  // Event qualifiers mirror the decode priority so each cycle counts for the condition that won.
  always_comb begin
    mem_ev = (state != ST_HALTED) && dmem_busy;
    br_ev  = !mem_ev && ex_br_taken &&
             ((eval_state == ST_RUN) || (eval_state == ST_DRAIN));
    lu_ev  = !mem_ev && !ex_br_taken && lu && (eval_state == ST_RUN);
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_stall_cnt  <= '0;
      br_flush_cnt  <= '0;
      mem_stall_cnt <= '0;
    end else begin
      if (lu_ev && (lu_stall_cnt != 16'hFFFF)) begin
        lu_stall_cnt <= lu_stall_cnt + 16'd1;
      end
      if (br_ev && (br_flush_cnt != 16'hFFFF)) begin
        br_flush_cnt <= br_flush_cnt + 16'd1;
      end
      if (mem_ev && (mem_stall_cnt != 16'hFFFF)) begin
        mem_stall_cnt <= mem_stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl (MEM_TIMEOUT=2, DRAIN_CYCLES=3).
// Inputs change 1ns after posedge; outputs are compared on the following negedge.
// Expected vectors are queued with the stimulus and popped by the negedge monitor.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] id_rs = '0, id_rt = '0, ex_dst = '0;
  logic       id_rs_vld = 1'b0, id_rt_vld = 1'b0, id_halt = 1'b0;
  logic       ex_mem_read = 1'b0, ex_br_taken = 1'b0, dmem_busy = 1'b0;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, halted, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] lu_stall_cnt, br_flush_cnt, mem_stall_cnt;
`endif

  always #5 clk = ~clk;

  hazard_stall_ctrl #(
    .ADDR_W(4),
    .MEM_TIMEOUT(2),
    .DRAIN_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .id_rs(id_rs),
    .id_rt(id_rt),
    .id_rs_vld(id_rs_vld),
    .id_rt_vld(id_rt_vld),
    .id_halt(id_halt),
    .ex_dst(ex_dst),
    .ex_mem_read(ex_mem_read),
    .ex_br_taken(ex_br_taken),
    .dmem_busy(dmem_busy),
    .pc_en(pc_en),
    .if_id_en(if_id_en),
    .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush),
    .halted(halted),
    .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .lu_stall_cnt(lu_stall_cnt),
    .br_flush_cnt(br_flush_cnt),
    .mem_stall_cnt(mem_stall_cnt)
`endif
  );

  // Vector order: pc, if_id, id_ex, ex_mem, mem_wb enables | if_id_flush, id_ex_flush | halted | mem_timeout
  localparam logic [8:0] E_ALL    = 9'b11111_0_0_0_0;
  localparam logic [8:0] E_LU     = 9'b00111_0_1_0_0;
  localparam logic [8:0] E_BR     = 9'b11111_1_1_0_0;
  localparam logic [8:0] E_HALT   = 9'b00111_0_0_0_0;
  localparam logic [8:0] E_DRAIN  = 9'b00111_0_1_0_0;
  localparam logic [8:0] E_STALL  = 9'b00000_0_0_0_0;
  localparam logic [8:0] E_HALTED = 9'b00000_0_0_1_0;
  localparam logic [8:0] TO       = 9'b00000_0_0_0_1;

  typedef struct {
    string      tag;
    logic [8:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  wire [8:0] obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                    if_id_flush, id_ex_flush, halted, mem_timeout};

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Monitor: one expected vector per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      sb_t e;
      e = sb_q.pop_front();
      chk(e.tag, obs, e.exp);
    end
  end

  // Apply one cycle of inputs and queue the output vector they must produce.
  task automatic step(input string tag, input logic rst,
                      input logic [3:0] rs, input logic rs_v,
                      input logic [3:0] rt, input logic rt_v,
                      input logic [3:0] dst, input logic mrd,
                      input logic br, input logic busy, input logic halt,
                      input logic [8:0] exp);
    sb_t e;
    rst_n       = rst;
    id_rs       = rs;
    id_rs_vld   = rs_v;
    id_rt       = rt;
    id_rt_vld   = rt_v;
    ex_dst      = dst;
    ex_mem_read = mrd;
    ex_br_taken = br;
    dmem_busy   = busy;
    id_halt     = halt;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input logic [8:0] exp);
    step(tag, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp);
  endtask

  task automatic rst_cycle(input string tag);
    step(tag, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_STALL);
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset: nothing enabled, status clear.
    rst_cycle("reset0");
    rst_cycle("reset1");
    idle("run_after_reset", E_ALL);

    // Load-use on rs, then the load moves on.
    step("lu_rs", 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, E_LU);
    step("lu_done", 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, E_ALL);
    // Register 0 and unused operand never hazard; a read rt does.
    step("lu_r0", 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_ALL);
    step("lu_rt_invalid", 1'b1, 4'd1, 1'b1, 4'd5, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, E_ALL);
    step("lu_rt", 1'b1, 4'd1, 1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, E_LU);
    // Branch wins over load-use.
    step("br_over_lu", 1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, E_BR);
    idle("after_br", E_ALL);

    // Memory stall of 3 cycles with timeout 2: flag from the 3rd cycle, sticky.
    step("mem3_c1", 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_STALL);
    step("mem3_c2", 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_STALL);
    step("mem3_c3", 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_STALL | TO);
    idle("mem3_resume", E_ALL | TO);
    idle("mem3_sticky", E_ALL | TO);
    rst_cycle("reset_clears_to");
    idle("run_after_reset2", E_ALL);

    // Memory stall held 4 cycles: frozen for exactly 4 cycles; branch under stall ignored.
    step("mem4_c1", 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, E_STALL);
    step("mem4_c2", 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_STALL);
    step("mem4_c3", 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_STALL | TO);
    step("mem4_c4", 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_STALL | TO);
    idle("mem4_resume", E_ALL | TO);
    rst_cycle("reset3");

    // Halt: halted exactly 3 cycles after halt in ID; busy and branch then ignored.
    step("halt_id", 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_HALT);
    step("drain1", 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_DRAIN);
    step("drain2", 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_DRAIN);
    idle("halted1", E_HALTED);
    step("halted_busy", 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_HALTED);
    step("halted_br", 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_HALTED);
    rst_cycle("reset_from_halted");
    idle("run_after_halt", E_ALL);

    // Branch in the 2nd drain cycle cancels the halt.
    step("halt_id_b", 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_HALT);
    idle("drain1_b", E_DRAIN);
    step("drain2_br", 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_BR);
    idle("after_drain_br1", E_ALL);
    idle("after_drain_br2", E_ALL);
    idle("after_drain_br3", E_ALL);

    // Memory stall inside the drain resumes the drain where it left off.
    step("halt_id_m", 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_HALT);
    idle("drain1_m", E_DRAIN);
    step("drain_busy", 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_STALL);
    idle("drain2_m", E_DRAIN);
    idle("halted_m", E_HALTED);
    rst_cycle("reset4");

    // Asynchronous reset between clock edges in the middle of a drain.
    idle("run_pre_async", E_ALL);
    step("halt_id_r", 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_HALT);
    idle("drain1_r", E_DRAIN);
    rst_cycle("async_rst_mid_drain");
    idle("run_after_async", E_ALL);
    idle("run_after_async2", E_ALL);

    chk("sb_empty", 9'(sb_q.size()), 9'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
